lock_supervisor: RTL

Supervises one lock loop by watching a monitored signal against a lock window and deciding when the loop is locked, when lock is lost, and when relock is attempted. It drives the relock scan engine through `out_of_lock` and `relock_reset`, gates the PID enable, and retries failed relocks a bounded number of times before latching a fault. It sits between the lock-in/PID datapath and the relock scan engine and is configured from the register bank.

---
 rtl/lock_pkg.sv | 17 +
 rtl/lock_supervisor_win_qualifier.sv | 46 ++++
 rtl/lock_supervisor.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the lock supervisor: state codes (also used by the
// register map) and the fixed relock-reset pulse length.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_ACQUIRE  = 3'd1,
        ST_LOCKED   = 3'd2,
        ST_HOLDOFF  = 3'd3,
        ST_RELOCK   = 3'd4,
        ST_RETRY    = 3'd5,
        ST_FAULT    = 3'd6
    } lock_state_t;

    localparam int unsigned RETRY_LEN = 4;

endpackage

// File: rtl/lock_supervisor_win_qualifier.sv
// Window compare with registered result and a consecutive-sample counter that
// flags the Nth qualifying sample (target 0 is treated as 1).
module win_qualifier #(
    parameter int R  = 14,
    parameter int CW = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                load1,
    input  logic                pol,
    input  logic signed [R-1:0] lock_sig,
    input  logic signed [R-1:0] th_lo,
    input  logic signed [R-1:0] th_hi,
    input  logic [CW-1:0]       target,
    output logic                in_win_r,
    output logic                tc
);

    logic          in_win;
    logic          qual;
    logic [CW-1:0] qcnt;
    logic [CW-1:0] target_eff;

    assign in_win     = (th_lo <= lock_sig) && (lock_sig <= th_hi);
    assign qual       = pol ? in_win_r : !in_win_r;
    assign target_eff = (target == '0) ? CW'(1) : target;
    assign tc         = qual && (({1'b0, qcnt} + (CW+1)'(1)) >= {1'b0, target_eff});

    always_ff @(posedge clk) begin
        if (rst) begin
            in_win_r <= 1'b0;
            qcnt     <= '0;
        end else begin
            in_win_r <= in_win;
            // load1 seeds the count with the sample that triggered the state change
            if (load1)
                qcnt <= CW'(1);
            else if (clr || !qual)
                qcnt <= '0;
            else if (qcnt != '1)
                qcnt <= qcnt + CW'(1);
        end
    end

endmodule

// File: rtl/lock_supervisor.sv
// Lock supervisor FSM: qualifies lock/loss, drives the relock engine, bounds
// retries. Optional loss statistics under LOCK_SUPERVISOR_STATS_EN.
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int R  = 14,
    parameter int CW = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic signed [R-1:0] lock_sig,
    input  logic signed [R-1:0] th_lo,
    input  logic signed [R-1:0] th_hi,
    input  logic [CW-1:0]       holdoff,
    input  logic [CW-1:0]       settle,
    input  logic [3:0]          max_retries,
    input  logic                relock_fail,
    output logic                out_of_lock,
    output logic                relock_reset,
    output logic                pid_enable,
    output logic                fault,
    output logic [2:0]          state,
    output logic [3:0]          retry_cnt,
    output logic [15:0]         lock_lost_cnt
);

    localparam int unsigned RT_W = $clog2(RETRY_LEN);

    lock_state_t   state_q, state_next;
    logic          in_win_r, tc;
    logic          q_clr, q_load1, q_pol;
    logic [CW-1:0] q_target;
    logic          fail_q, fail_qq, fail_rise;
    logic [RT_W-1:0] rtimer;
    logic          retry_inc, retry_clr, lost_inc;

    assign q_pol    = (state_q != ST_HOLDOFF);
    assign q_target = (state_q == ST_HOLDOFF) ? holdoff : settle;
    assign q_clr    = (state_next != state_q);
    assign q_load1  = (state_q == ST_LOCKED) && (state_next == ST_HOLDOFF);

    win_qualifier #(.R(R), .CW(CW)) u_qual (
        .clk      (clk),
        .rst      (rst),
        .clr      (q_clr),
        .load1    (q_load1),
        .pol      (q_pol),
        .lock_sig (lock_sig),
        .th_lo    (th_lo),
        .th_hi    (th_hi),
        .target   (q_target),
        .in_win_r (in_win_r),
        .tc       (tc)
    );

    assign fail_rise = fail_q && !fail_qq;

    always_comb begin
        state_next = state_q;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        lost_inc   = 1'b0;
        case (state_q)
            ST_DISABLED: if (enable) state_next = ST_ACQUIRE;
            ST_ACQUIRE:  if (tc) state_next = ST_LOCKED;
            ST_LOCKED: begin
                // A one-sample holdoff is already satisfied by the first loss sample
                if (!in_win_r) begin
                    if (holdoff <= CW'(1)) begin
                        state_next = ST_RELOCK;
                        retry_clr  = 1'b1;
                        lost_inc   = 1'b1;
                    end else begin
                        state_next = ST_HOLDOFF;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (in_win_r) begin
                    state_next = ST_LOCKED;
                end else if (tc) begin
                    state_next = ST_RELOCK;
                    retry_clr  = 1'b1;
                    lost_inc   = 1'b1;
                end
            end
            ST_RELOCK: begin
                if (tc) begin
                    state_next = ST_LOCKED;
                    retry_clr  = 1'b1;
                end else if (fail_rise) begin
                    state_next = (retry_cnt == max_retries) ? ST_FAULT : ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (rtimer == RT_W'(RETRY_LEN - 1)) begin
                    state_next = ST_RELOCK;
                    retry_inc  = 1'b1;
                end
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_DISABLED;
        endcase
        if (!enable) begin
            state_next = ST_DISABLED;
            retry_inc  = 1'b0;
            retry_clr  = 1'b0;
            lost_inc   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_DISABLED;
            fail_q    <= 1'b0;
            fail_qq   <= 1'b0;
            rtimer    <= '0;
            retry_cnt <= '0;
        end else begin
            state_q <= state_next;
            fail_q  <= relock_fail;
            fail_qq <= fail_q;
            rtimer  <= (state_q == ST_RETRY) ? rtimer + RT_W'(1) : '0;
            if (retry_clr)
                retry_cnt <= '0;
            else if (retry_inc)
                retry_cnt <= retry_cnt + 4'd1;
        end
    end

`ifdef LOCK_SUPERVISOR_STATS_EN
    logic [15:0] lost_cnt_q;
    always_ff @(posedge clk) begin
        if (rst)
            lost_cnt_q <= '0;
        else if (lost_inc && (lost_cnt_q != 16'hFFFF))
            lost_cnt_q <= lost_cnt_q + 16'd1;
    end
    assign lock_lost_cnt = lost_cnt_q;
`else
    logic unused_lost_inc;
    assign unused_lost_inc = lost_inc;
    assign lock_lost_cnt   = '0;
`endif

    assign state        = state_q;
    assign out_of_lock  = (state_q == ST_RELOCK) || (state_q == ST_RETRY);
    assign pid_enable   = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED) ||
                          (state_q == ST_HOLDOFF) || (state_q == ST_RELOCK) ||
                          (state_q == ST_RETRY);
    // relock_reset is released by rst without waiting for the clock edge
    assign relock_reset = (state_q == ST_RETRY) && !rst;
    assign fault        = (state_q == ST_FAULT);

endmodule
